nf10_axis_width_converter: RTL and testbench

Parametrised AXI4-Stream width converter for the NetFPGA-10G datapath.
- Handles downsizing (wide to narrow), upsizing (narrow to wide) and equal-width pass-through in one block, selected by parameters.
- Carries tstrb, tlast and the NetFPGA tuser metadata (len/src/dst fields).
- Sits between 256-bit core pipeline stages and 64-bit MAC/DMA-side ports, in either direction.

---
 rtl/nf10_axis_width_converter.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_nf10_axis_width_converter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_axis_width_converter.sv
// nf10_axis_width_converter
// AXI4-Stream width converter for the NetFPGA-10G datapath. It downsizes,
// upsizes or passes through depending on the two data-width parameters, and
// carries tstrb, tlast and the NetFPGA tuser metadata (len/spt/dpt).
// The tuser word of a packet is taken from its first accepted beat and is
// repeated on every output beat of that packet.
// Optional feature macro: NF10_AXIS_CONV_OUT_SLICE_EN adds a two-entry skid
// slice on the m_axis side. This registers every m_axis_* output, adds one
// cycle of latency and removes the combinational path from m_axis_tready to
// s_axis_tready. Throughput is unchanged.

module nf10_axis_width_converter #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_M_AXIS_DATA_WIDTH = 64,
  parameter int C_TUSER_WIDTH       = 128,
  parameter int C_LEN_WIDTH         = 16,
  parameter int C_SPT_WIDTH         = 8,
  parameter int C_DPT_WIDTH         = 8
) (
  input  logic                             axi_aclk,
  input  logic                             axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]         s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
);

  localparam int S_W    = C_S_AXIS_DATA_WIDTH;
  localparam int M_W    = C_M_AXIS_DATA_WIDTH;
  localparam int S_B    = S_W / 8;
  localparam int M_B    = M_W / 8;
  localparam int TU_W   = C_TUSER_WIDTH;
  localparam int META_W = C_LEN_WIDTH + C_SPT_WIDTH + C_DPT_WIDTH;

  // Converter-side master stream, ahead of the optional output slice.
  logic [M_W-1:0]  c_tdata;
  logic [M_B-1:0]  c_tstrb;
  logic [TU_W-1:0] c_tuser;
  logic            c_tvalid;
  logic            c_tlast;
  logic            c_tready;

  logic            s_tready;
  logic            s_fire;
  logic            sop_q;
  logic [TU_W-1:0] pkt_tuser_q;
  logic [TU_W-1:0] beat_tuser;
  logic [TU_W-1:0] s_tuser_fields;

  // Named metadata fields. They pass through unmodified; naming them here
  // documents the layout the rest of the pipeline relies on.
  logic [C_LEN_WIDTH-1:0] s_len;
  logic [C_SPT_WIDTH-1:0] s_spt;
  logic [C_DPT_WIDTH-1:0] s_dpt;

  assign s_len = s_axis_tuser[C_LEN_WIDTH-1:0];
  assign s_spt = s_axis_tuser[C_LEN_WIDTH +: C_SPT_WIDTH];
  assign s_dpt = s_axis_tuser[C_LEN_WIDTH+C_SPT_WIDTH +: C_DPT_WIDTH];

  generate
    if (META_W < TU_W) begin : g_meta_pad
      assign s_tuser_fields = {s_axis_tuser[TU_W-1:META_W], s_dpt, s_spt, s_len};
    end else begin : g_meta_full
      assign s_tuser_fields = {s_dpt, s_spt, s_len};
    end
  endgenerate

  assign s_axis_tready = s_tready;
  assign s_fire        = s_axis_tvalid & s_tready;

  // Only the first beat of a packet supplies tuser; later beats reuse it.
  assign beat_tuser = sop_q ? s_tuser_fields : pkt_tuser_q;

  // Packet tracking: SOP flag and the tuser captured at packet start.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      sop_q       <= 1'b1;
      pkt_tuser_q <= '0;
    end else if (s_fire) begin
      sop_q       <= s_axis_tlast;
      pkt_tuser_q <= beat_tuser;
    end
  end

  generate
    if (S_W > M_W) begin : g_down
      // ------------------------------------------------------------------
      // Downsize: one wide beat is held and emitted lane by lane, LSB first.
      // ------------------------------------------------------------------
      localparam int N  = S_W / M_W;
      localparam int LW = $clog2(N);

      logic            buf_valid_q;
      logic [S_W-1:0]  buf_data_q;
      logic [S_B-1:0]  buf_strb_q;
      logic            buf_last_q;
      logic [TU_W-1:0] buf_tuser_q;
      logic [LW-1:0]   lane_q;
      logic [LW-1:0]   end_lane_q;
      logic [LW-1:0]   end_lane_d;
      logic            at_end;

      // Final lane of the incoming beat: top lane normally, highest lane with
      // any strobe on a tlast beat, lane 0 if a tlast beat has no strobes.
      // NOTE: end_lane_d gets a default before any conditional assignment so
      // this block can never infer a latch.
      always_comb begin
        end_lane_d = LW'(N - 1);
        if (s_axis_tlast) begin
          end_lane_d = '0;
          for (int i = 1; i < N; i++) begin
            if (|s_axis_tstrb[i*M_B +: M_B]) end_lane_d = LW'(i);
          end
        end
      end

      assign at_end   = (lane_q == end_lane_q);
      // A new beat may load while the last lane of the current one leaves.
      assign s_tready = axi_resetn & (~buf_valid_q | (at_end & c_tready));

      assign c_tvalid = buf_valid_q;
      assign c_tdata  = buf_data_q[lane_q*M_W +: M_W];
      assign c_tstrb  = buf_strb_q[lane_q*M_B +: M_B];
      assign c_tlast  = buf_last_q & at_end;
      assign c_tuser  = buf_tuser_q;

      // Beat buffer and lane walker.
      // NOTE: the data buffers are reset as well as the valid flag so the
      // unsliced m_axis_* outputs read 0 during and straight out of reset.
      always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
          buf_valid_q <= 1'b0;
          buf_data_q  <= '0;
          buf_strb_q  <= '0;
          buf_last_q  <= 1'b0;
          buf_tuser_q <= '0;
          lane_q      <= '0;
          end_lane_q  <= '0;
        end else if (s_fire) begin
          buf_valid_q <= 1'b1;
          buf_data_q  <= s_axis_tdata;
          buf_strb_q  <= s_axis_tstrb;
          buf_last_q  <= s_axis_tlast;
          buf_tuser_q <= beat_tuser;
          lane_q      <= '0;
          end_lane_q  <= end_lane_d;
        end else if (buf_valid_q && c_tready) begin
          if (at_end) begin
            buf_valid_q <= 1'b0;
            lane_q      <= '0;
          end else begin
            lane_q      <= lane_q + 1'b1;
          end
        end
      end

    end else if (S_W < M_W) begin : g_up
      // ------------------------------------------------------------------
      // Upsize: narrow beats fill lanes LSB first; a full set of lanes or a
      // tlast beat moves the assembled word to the output register.
      // ------------------------------------------------------------------
      localparam int N  = M_W / S_W;
      localparam int LW = $clog2(N);

      logic [M_W-1:0]  acc_data_q;
      logic [M_B-1:0]  acc_strb_q;
      logic [LW-1:0]   lane_q;
      logic [M_W-1:0]  fill_data_d;
      logic [M_B-1:0]  fill_strb_d;
      logic            flush;
      logic            out_valid_q;
      logic [M_W-1:0]  out_data_q;
      logic [M_B-1:0]  out_strb_q;
      logic            out_last_q;
      logic [TU_W-1:0] out_tuser_q;

      // Accumulator with the incoming beat merged into the current lane.
      always_comb begin
        fill_data_d = acc_data_q;
        fill_strb_d = acc_strb_q;
        fill_data_d[lane_q*S_W +: S_W] = s_axis_tdata;
        fill_strb_d[lane_q*S_B +: S_B] = s_axis_tstrb;
      end

      assign flush    = s_axis_tlast | (lane_q == LW'(N - 1));
      // Filling may continue while the previous full word drains.
      assign s_tready = axi_resetn & (~out_valid_q | c_tready);

      assign c_tvalid = out_valid_q;
      assign c_tdata  = out_data_q;
      assign c_tstrb  = out_strb_q;
      assign c_tlast  = out_last_q;
      assign c_tuser  = out_tuser_q;

      // Lane accumulator and output word register. The accumulator is
      // cleared on every flush so unfilled lanes carry zero data and strobes
      // and no word ever mixes bytes from two packets.
      always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
          acc_data_q  <= '0;
          acc_strb_q  <= '0;
          lane_q      <= '0;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_strb_q  <= '0;
          out_last_q  <= 1'b0;
          out_tuser_q <= '0;
        end else begin
          if (out_valid_q && c_tready) out_valid_q <= 1'b0;
          if (s_fire) begin
            if (flush) begin
              out_valid_q <= 1'b1;
              out_data_q  <= fill_data_d;
              out_strb_q  <= fill_strb_d;
              out_last_q  <= s_axis_tlast;
              out_tuser_q <= beat_tuser;
              acc_data_q  <= '0;
              acc_strb_q  <= '0;
              lane_q      <= '0;
            end else begin
              acc_data_q  <= fill_data_d;
              acc_strb_q  <= fill_strb_d;
              lane_q      <= lane_q + 1'b1;
            end
          end
        end
      end

    end else begin : g_same
      // ------------------------------------------------------------------
      // Equal widths: one register stage, full throughput.
      // ------------------------------------------------------------------
      logic            v_q;
      logic [M_W-1:0]  data_q;
      logic [M_B-1:0]  strb_q;
      logic            last_q;
      logic [TU_W-1:0] tuser_q;

      assign s_tready = axi_resetn & (~v_q | c_tready);
      assign c_tvalid = v_q;
      assign c_tdata  = data_q;
      assign c_tstrb  = strb_q;
      assign c_tlast  = last_q;
      assign c_tuser  = tuser_q;

      // Pass-through pipeline register.
      always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
          v_q     <= 1'b0;
          data_q  <= '0;
          strb_q  <= '0;
          last_q  <= 1'b0;
          tuser_q <= '0;
        end else if (s_fire) begin
          v_q     <= 1'b1;
          data_q  <= s_axis_tdata;
          strb_q  <= s_axis_tstrb;
          last_q  <= s_axis_tlast;
          tuser_q <= beat_tuser;
        end else if (v_q && c_tready) begin
          v_q     <= 1'b0;
        end
      end
    end
  endgenerate

`ifdef NF10_AXIS_CONV_OUT_SLICE_EN
  // Two-entry skid slice: main register drives m_axis_*, the skid register
  // catches the one beat already in flight when the sink stalls.
  typedef struct packed {
    logic [M_W-1:0]  data;
    logic [M_B-1:0]  strb;
    logic [TU_W-1:0] user;
    logic            last;
  } beat_t;

  beat_t c_beat;
  beat_t main_q;
  beat_t skid_q;
  logic  main_valid_q;
  logic  skid_valid_q;

  assign c_beat   = {c_tdata, c_tstrb, c_tuser, c_tlast};
  assign c_tready = ~skid_valid_q;

  assign m_axis_tvalid = main_valid_q;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tstrb  = main_q.strb;
  assign m_axis_tuser  = main_q.user;
  assign m_axis_tlast  = main_q.last;

  // Refill the main register from skid first, else straight from the
  // converter; park a beat in skid when the main register is stalled.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q || m_axis_tready) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= c_tvalid;
        if (c_tvalid) main_q <= c_beat;
      end
    end else if (c_tvalid && !skid_valid_q) begin
      skid_q       <= c_beat;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign m_axis_tvalid = c_tvalid;
  assign m_axis_tdata  = c_tdata;
  assign m_axis_tstrb  = c_tstrb;
  assign m_axis_tuser  = c_tuser;
  assign m_axis_tlast  = c_tlast;
  assign c_tready      = m_axis_tready;
`endif

endmodule

// File: tb/tb_nf10_axis_width_converter.sv
// Testbench for nf10_axis_width_converter: a 256->64 instance (A) and a
// 64->256 instance (B). Expected beats are produced by a small reference
// model when an input beat is accepted and compared as the DUT emits them.
// Honours NF10_AXIS_CONV_OUT_SLICE_EN for the latency expectations.

module tb_nf10_axis_width_converter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT A: 256 -> 64 ----------------
  logic [255:0] a_s_tdata;
  logic [31:0]  a_s_tstrb;
  logic [127:0] a_s_tuser;
  logic         a_s_tvalid, a_s_tready, a_s_tlast;
  logic [63:0]  a_m_tdata;
  logic [7:0]   a_m_tstrb;
  logic [127:0] a_m_tuser;
  logic         a_m_tvalid, a_m_tlast;
  logic         a_m_tready = 1'b1;
  bit           a_toggle   = 1'b0;

  nf10_axis_width_converter #(
    .C_S_AXIS_DATA_WIDTH(256), .C_M_AXIS_DATA_WIDTH(64), .C_TUSER_WIDTH(128),
    .C_LEN_WIDTH(16), .C_SPT_WIDTH(8), .C_DPT_WIDTH(8)
  ) u_dut_a (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tstrb(a_s_tstrb), .s_axis_tuser(a_s_tuser),
    .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready), .s_axis_tlast(a_s_tlast),
    .m_axis_tdata(a_m_tdata), .m_axis_tstrb(a_m_tstrb), .m_axis_tuser(a_m_tuser),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready), .m_axis_tlast(a_m_tlast)
  );

  // ---------------- DUT B: 64 -> 256 ----------------
  logic [63:0]  b_s_tdata;
  logic [7:0]   b_s_tstrb;
  logic [127:0] b_s_tuser;
  logic         b_s_tvalid, b_s_tready, b_s_tlast;
  logic [255:0] b_m_tdata;
  logic [31:0]  b_m_tstrb;
  logic [127:0] b_m_tuser;
  logic         b_m_tvalid, b_m_tlast;
  logic         b_m_tready = 1'b1;

  nf10_axis_width_converter #(
    .C_S_AXIS_DATA_WIDTH(64), .C_M_AXIS_DATA_WIDTH(256), .C_TUSER_WIDTH(128),
    .C_LEN_WIDTH(16), .C_SPT_WIDTH(8), .C_DPT_WIDTH(8)
  ) u_dut_b (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tstrb(b_s_tstrb), .s_axis_tuser(b_s_tuser),
    .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast),
    .m_axis_tdata(b_m_tdata), .m_axis_tstrb(b_m_tstrb), .m_axis_tuser(b_m_tuser),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast)
  );

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic         last;
    logic [127:0] user;
    logic         endlane;
  } exp_a_t;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic [127:0] user;
  } exp_b_t;

  exp_a_t q_a[$];
  exp_b_t q_b[$];
  int     a_out_cnt = 0;
  int     b_out_cnt = 0;

  // Reference-model state
  logic         sop_a = 1'b1, sop_b = 1'b1;
  logic [127:0] cur_user_a, cur_user_b;
  logic [255:0] b_acc_d = '0;
  logic [31:0]  b_acc_s = '0;
  int           b_lane  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 256->64 model: lanes LSB first, trailing strobe-free lanes dropped on tlast.
  task automatic model_a(input logic [255:0] d, input logic [31:0] s,
                         input logic [127:0] u, input logic l);
    exp_a_t e;
    int hi;
    if (sop_a) cur_user_a = u;
    hi = 3;
    if (l) begin
      hi = 0;
      for (int i = 0; i < 4; i++) if (s[i*8 +: 8] != 8'h00) hi = i;
    end
    for (int i = 0; i <= hi; i++) begin
      e.data    = d[i*64 +: 64];
      e.strb    = s[i*8 +: 8];
      e.last    = l && (i == hi);
      e.user    = cur_user_a;
      e.endlane = (i == hi);
      q_a.push_back(e);
    end
    sop_a = l;
  endtask

  // 64->256 model: fill lanes, emit on 4th lane or tlast, zero unfilled lanes.
  task automatic model_b(input logic [63:0] d, input logic [7:0] s,
                         input logic [127:0] u, input logic l);
    exp_b_t e;
    if (sop_b) cur_user_b = u;
    b_acc_d[b_lane*64 +: 64] = d;
    b_acc_s[b_lane*8 +: 8]   = s;
    b_lane++;
    if (b_lane == 4 || l) begin
      e.data = b_acc_d;
      e.strb = b_acc_s;
      e.last = l;
      e.user = cur_user_b;
      q_b.push_back(e);
      b_acc_d = '0;
      b_acc_s = '0;
      b_lane  = 0;
    end
    sop_b = l;
  endtask

  task automatic send_a(input logic [255:0] d, input logic [31:0] s,
                        input logic [127:0] u, input logic l);
    logic acc;
    acc = 1'b0;
    a_s_tdata = d; a_s_tstrb = s; a_s_tuser = u; a_s_tlast = l; a_s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = a_s_tready;
      @(posedge clk); #1;
    end
    a_s_tvalid = 1'b0;
    check("a_accept", acc, 1'b1);
    if (acc) model_a(d, s, u, l);
  endtask

  task automatic send_b(input logic [63:0] d, input logic [7:0] s,
                        input logic [127:0] u, input logic l);
    logic acc;
    acc = 1'b0;
    b_s_tdata = d; b_s_tstrb = s; b_s_tuser = u; b_s_tlast = l; b_s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = b_s_tready;
      @(posedge clk); #1;
    end
    b_s_tvalid = 1'b0;
    check("b_accept", acc, 1'b1);
    if (acc) model_b(d, s, u, l);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 400 && q_a.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("a_drain", q_a.size(), 0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 400 && q_b.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("b_drain", q_b.size(), 0);
  endtask

  // Sink-ready pattern for A: held high, or toggling 1010... when a_toggle.
  always @(posedge clk) begin
    #1;
    if (a_toggle) a_m_tready = ~a_m_tready;
    else          a_m_tready = 1'b1;
  end

  // Monitor A: scoreboard compare, stall stability, early-ready detection.
  logic         a_hold = 1'b0;
  logic [63:0]  a_hd;
  logic [7:0]   a_hs;
  logic [127:0] a_hu;
  logic         a_hl;

  always @(negedge clk) begin : mon_a
    exp_a_t e;
    if (!rst_n) begin
      a_hold = 1'b0;
    end else begin
      if (a_hold) begin
        check("a_stall_valid", a_m_tvalid, 1'b1);
        check("a_stall_data", a_m_tdata, a_hd);
        check("a_stall_strb", a_m_tstrb, a_hs);
        check("a_stall_user", a_m_tuser, a_hu);
        check("a_stall_last", a_m_tlast, a_hl);
      end
`ifndef NF10_AXIS_CONV_OUT_SLICE_EN
      if (a_m_tvalid && a_s_tready && q_a.size() > 0)
        check("a_sready_early", {a_m_tready, q_a[0].endlane}, 2'b11);
`endif
      if (a_m_tvalid && a_m_tready) begin
        a_out_cnt++;
        if (q_a.size() == 0) begin
          check("a_unexpected_beat", q_a.size(), 1);
        end else begin
          e = q_a.pop_front();
          check("a_data", a_m_tdata, e.data);
          check("a_strb", a_m_tstrb, e.strb);
          check("a_last", a_m_tlast, e.last);
          check("a_user", a_m_tuser, e.user);
        end
      end
      a_hold = a_m_tvalid && !a_m_tready;
      a_hd = a_m_tdata; a_hs = a_m_tstrb; a_hu = a_m_tuser; a_hl = a_m_tlast;
    end
  end

  // Monitor B: scoreboard compare.
  always @(negedge clk) begin : mon_b
    exp_b_t e;
    if (rst_n && b_m_tvalid && b_m_tready) begin
      b_out_cnt++;
      if (q_b.size() == 0) begin
        check("b_unexpected_beat", q_b.size(), 1);
      end else begin
        e = q_b.pop_front();
        check("b_data", b_m_tdata, e.data);
        check("b_strb", b_m_tstrb, e.strb);
        check("b_last", b_m_tlast, e.last);
        check("b_user", b_m_tuser, e.user);
      end
    end
  end

  // Hard time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  logic [255:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic [127:0] u1;
  int base;

  initial begin
    d1 = {64'h4444_4444_4444_4404, 64'h3333_3333_3333_3303, 64'h2222_2222_2222_2202, 64'h1111_1111_1111_1101};
    d2 = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    d3 = {4{64'h5A5A_5A5A_5A5A_5A5A}};
    d4 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    d5 = {64'h0808_0808_0808_0808, 64'h0707_0707_0707_0707, 64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505};
    d6 = {64'hF4F4_0000_1111_2222, 64'hF3F3_0000_1111_2222, 64'hF2F2_0000_1111_2222, 64'hF1F1_0000_1111_2222};
    d7 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    d8 = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
    u1 = 128'hDEAD_BEEF_0000_0000_0000_0000_0102_0040;

    rst_n = 1'b0;
    a_s_tvalid = 1'b0; a_s_tdata = '0; a_s_tstrb = '0; a_s_tuser = '0; a_s_tlast = 1'b0;
    b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tstrb = '0; b_s_tuser = '0; b_s_tlast = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_sready", a_s_tready, 1'b0);
    check("rst_a_valid", a_m_tvalid, 1'b0);
    check("rst_a_data", a_m_tdata, 64'h0);
    check("rst_a_user", a_m_tuser, 128'h0);
    check("rst_a_last", a_m_tlast, 1'b0);
    check("rst_b_sready", b_s_tready, 1'b0);
    check("rst_b_valid", b_m_tvalid, 1'b0);
    check("rst_b_strb", b_m_tstrb, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_a_sready", a_s_tready, 1'b1);
    check("rel_b_sready", b_s_tready, 1'b1);
    @(posedge clk); #1;

    // 256->64 full beat with tlast: 4 beats, latency and back-to-back output
    base = a_out_cnt;
    send_a(d1, 32'hFFFF_FFFF, u1, 1'b1);
    @(negedge clk);
`ifdef NF10_AXIS_CONV_OUT_SLICE_EN
    check("a_lat_slice_early", a_m_tvalid, 1'b0);
    @(negedge clk);
`endif
    check("a_lat_first", a_m_tvalid, 1'b1);
    check("a_lat_lane0", a_m_tdata, d1[63:0]);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("a_back2back", a_m_tvalid, 1'b1);
    end
    drain_a();
    check("a_t1_count", a_out_cnt - base, 4);

    // Partial strobes on tlast: only the lower two lanes go out
    base = a_out_cnt;
    send_a(d2, 32'h0000_FFFF, 128'h0000_0000_0000_0000_0000_0000_0304_0010, 1'b1);
    drain_a();
    check("a_t2_count", a_out_cnt - base, 2);

    // All-zero strobe tlast beat: a single lane-0 beat with strb 0
    base = a_out_cnt;
    send_a(d3, 32'h0000_0000, 128'h0000_0000_0000_0000_0000_0000_0506_0000, 1'b1);
    drain_a();
    check("a_t3_count", a_out_cnt - base, 1);

    // Backpressure 1010..., two back-to-back packets; later-beat tuser ignored
    a_toggle = 1'b1;
    base = a_out_cnt;
    send_a(d4, 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0708_0050, 1'b0);
    send_a(d5, 32'h0000_0FFF, 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0, 1'b1);
    send_a(d6, 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_090A_0020, 1'b1);
    drain_a();
    check("a_bp_count", a_out_cnt - base, 10);
    a_toggle = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset after two of four lanes of a non-final beat
    base = a_out_cnt;
    send_a(d7, 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0B0C_0080, 1'b0);
    for (int i = 0; i < 50 && a_out_cnt < base + 2; i++) begin
      @(posedge clk); #2;
    end
    check("a_rst_lanes_before", a_out_cnt - base, 2);
    rst_n = 1'b0;
    #1;
    check("a_rst_valid_drop", a_m_tvalid, 1'b0);
    check("a_rst_sready", a_s_tready, 1'b0);
    q_a.delete();
    sop_a = 1'b1;
    q_b.delete();
    sop_b = 1'b1; b_lane = 0; b_acc_d = '0; b_acc_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = a_out_cnt;
    send_a(d8, 32'h0000_00FF, 128'h0000_0000_0000_0000_0000_0000_0D0E_0008, 1'b1);
    drain_a();
    check("a_post_rst_count", a_out_cnt - base, 1);

    // 64->256: three beats then tlast -> one partial output word
    base = b_out_cnt;
    send_b(64'h1111_2222_3333_4444, 8'hFF, 128'h0000_0000_0000_0000_0000_0000_0201_0018, 1'b0);
    send_b(64'h5555_6666_7777_8888, 8'hFF, 128'hBAD1_BAD1_BAD1_BAD1_BAD1_BAD1_BAD1_BAD1, 1'b0);
    send_b(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 128'hBAD2_BAD2_BAD2_BAD2_BAD2_BAD2_BAD2_BAD2, 1'b1);
    @(negedge clk);
`ifdef NF10_AXIS_CONV_OUT_SLICE_EN
    check("b_lat_slice_early", b_m_tvalid, 1'b0);
    @(negedge clk);
`endif
    check("b_lat_valid", b_m_tvalid, 1'b1);
    check("b_lat_strb", b_m_tstrb, 32'h00FF_FFFF);
    check("b_lat_last", b_m_tlast, 1'b1);
    drain_b();
    check("b_t1_count", b_out_cnt - base, 1);

    // 1-beat packet then a 4-beat packet: never merged into one word
    base = b_out_cnt;
    send_b(64'hA0A0_A0A0_A0A0_A0A0, 8'h0F, 128'h0000_0000_0000_0000_0000_0000_0403_0004, 1'b1);
    send_b(64'hB1B1_B1B1_B1B1_B1B1, 8'hFF, 128'h0000_0000_0000_0000_0000_0000_0605_001C, 1'b0);
    send_b(64'hB2B2_B2B2_B2B2_B2B2, 8'hFF, 128'h0, 1'b0);
    send_b(64'hB3B3_B3B3_B3B3_B3B3, 8'hFF, 128'h0, 1'b0);
    send_b(64'hB4B4_B4B4_B4B4_B4B4, 8'h0F, 128'h0, 1'b1);
    drain_b();
    check("b_t2_count", b_out_cnt - base, 2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
